// File: rtl/lfsr_msg_gen.sv
// Fibonacci LFSR message generator: loads a seed, then emits one LFSR value per
// valid/ready transfer until the seed recurs or the programmed transfer limit is reached.
module lfsr_msg_gen #(
    parameter int           N      = 64,
    parameter logic [N-1:0] TAPS   = 64'h0000_0000_D800_0000,
    parameter bit           INVERT = 1'b1,
    parameter int           CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic [N-1:0]     seed,
    input  logic [CNT_W-1:0] limit,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrapped
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_next;
    logic [N-1:0]     lfsr, seed_reg, nxt;
    logic [CNT_W-1:0] limit_reg, count_inc;
    logic             fb, xfer, hit_limit, hit_seed;
    logic             load, advance, bump, finish, wrap_hit;

    always_comb begin
        fb        = (^(lfsr & TAPS)) ^ INVERT;
        nxt       = {fb, lfsr[N-1:1]};
        count_inc = (count == '1) ? count : count + CNT_ONE;
        xfer      = (state == RUN) && out_ready;
        hit_limit = (limit_reg != '0) && (count_inc == limit_reg);
        hit_seed  = (nxt == seed_reg);
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        bump       = 1'b0;
        finish     = 1'b0;
        wrap_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (xfer) begin
                    bump = 1'b1;
                    if (hit_limit) begin
                        finish = 1'b1;
                    end else if (hit_seed) begin
                        finish   = 1'b1;
                        wrap_hit = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
                // Terminal condition outranks pause; a transfer in the pausing cycle still counts.
                if (finish)     state_next = DONE;
                else if (pause) state_next = PAUSED;
            end
            PAUSED: begin
                if (!pause) state_next = RUN;
            end
            DONE: begin
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
            load       = 1'b0;
            advance    = 1'b0;
            bump       = 1'b0;
            finish     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= '0;
            seed_reg  <= '0;
            limit_reg <= '0;
            count     <= '0;
            wrapped   <= 1'b0;
        end else begin
            state <= state_next;
            if (abort) begin
                count   <= '0;
                wrapped <= 1'b0;
            end else if (load) begin
                lfsr      <= seed;
                seed_reg  <= seed;
                limit_reg <= limit;
                count     <= '0;
                wrapped   <= 1'b0;
            end else begin
                if (bump)    count   <= count_inc;
                if (advance) lfsr    <= nxt;
                if (finish)  wrapped <= wrap_hit;
            end
        end
    end

    always_comb begin
        out_valid = (state == RUN);
        out_data  = lfsr;
        busy      = (state == RUN) || (state == PAUSED);
        done      = (state == DONE);
    end

endmodule

// File: tb/tb_lfsr_msg_gen.sv
// Self-checking bench for lfsr_msg_gen (N=4, TAPS=4'b0011, XOR feedback) with a queue-based
// sequence model; a second instance with a 3-bit counter exercises count saturation.
module tb_lfsr_msg_gen;
    localparam int         N      = 4;
    localparam int         CNT_W  = 8;
    localparam logic [3:0] TAPS   = 4'b0011;
    localparam bit         INVERT = 1'b0;

    logic             clk = 1'b0;
    logic             rst, start, pause, abort, out_ready;
    logic [N-1:0]     seed;
    logic [CNT_W-1:0] limit;
    logic             out_valid, busy, done, wrapped;
    logic [N-1:0]     out_data;
    logic [CNT_W-1:0] count;
    logic             v2, b2, dn2, w2;
    logic [N-1:0]     d2;
    logic [2:0]       c2;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [3:0] s;
        logic [7:0] lim;
        int         pct;
        int         exp_cnt;
        bit         exp_wrap;
        bit         chk_sat;
    } vec_t;

    always #5 clk = ~clk;

    lfsr_msg_gen #(.N(N), .TAPS(TAPS), .INVERT(INVERT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
        .seed(seed), .limit(limit), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .count(count),
        .busy(busy), .done(done), .wrapped(wrapped)
    );

    lfsr_msg_gen #(.N(N), .TAPS(TAPS), .INVERT(INVERT), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
        .seed(seed), .limit(limit[2:0]), .out_ready(out_ready),
        .out_valid(v2), .out_data(d2), .count(c2),
        .busy(b2), .done(dn2), .wrapped(w2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Shift right, parity of tapped bits enters at the top.
    function automatic logic [3:0] step(input logic [3:0] v);
        int par = 0;
        for (int b = 0; b < N; b++) if (TAPS[b] && v[b]) par++;
        par = (par % 2) ^ int'(INVERT);
        return 4'((int'(v) / 2) + par * 8);
    endfunction

    task automatic build_model(input logic [3:0] s, input logic [7:0] lim);
        logic [3:0] v = s;
        exp_q.delete();
        for (int k = 0; k < 64; k++) begin
            exp_q.push_back(v);
            if (lim != 0 && exp_q.size() == int'(lim)) break;
            v = step(v);
            if (v == s) break;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_run(input logic [3:0] s, input logic [7:0] lim);
        seed  = s;
        limit = lim;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        out_ready = 1'b0;
        pause     = 1'b0;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic run_check(input string tag, input vec_t t);
        int         idx = 0;
        bit         stalled = 1'b0;
        logic [3:0] stall_val = '0;
        logic [3:0] last = '0;
        bit         rdy;
        build_model(t.s, t.lim);
        start_run(t.s, t.lim);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done) break;
            if (stalled) check({tag, " stall_hold"}, 32'(out_data), 32'(stall_val));
            check({tag, " valid"}, 32'(out_valid), 32'd1);
            rdy       = int'($urandom_range(99)) < t.pct;
            out_ready = rdy;
            if (out_valid && rdy) begin
                checks++;
                if (idx >= exp_q.size()) begin
                    errors++;
                    $display("FAIL %s extra_xfer: got data %0h beyond %0d expected", tag, out_data, exp_q.size());
                end else if (out_data !== exp_q[idx]) begin
                    errors++;
                    $display("FAIL %s data[%0d]: got %0h expected %0h", tag, idx, out_data, exp_q[idx]);
                end
                last    = out_data;
                idx++;
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled   = 1'b1;
                stall_val = out_data;
            end
            tick();
        end
        out_ready = 1'b0;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " n_xfers"}, 32'(idx), 32'(exp_q.size()));
        check({tag, " count"}, 32'(count), 32'(t.exp_cnt));
        check({tag, " wrapped"}, 32'(wrapped), 32'(t.exp_wrap));
        check({tag, " busy"}, 32'(busy), 32'd0);
        tick();
        check({tag, " no_valid_after_done"}, 32'(out_valid), 32'd0);
        check({tag, " data_held"}, 32'(out_data), 32'(last));
        check({tag, " done_level"}, 32'(done), 32'd1);
        if (t.chk_sat) begin
            check({tag, " sat_count"}, 32'(c2), 32'd7);
            check({tag, " sat_done"}, 32'(dn2), 32'd1);
            check({tag, " sat_wrapped"}, 32'(w2), 32'd1);
        end
        do_abort();
        check({tag, " abort_done"}, 32'(done), 32'd0);
        check({tag, " abort_count"}, 32'(count), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        vec_t rv;
        rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; out_ready = 1'b0;
        seed = '0; limit = '0;
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        check("reset valid", 32'(out_valid), 32'd0);
        check("reset data", 32'(out_data), 32'd0);
        check("reset count", 32'(count), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset wrapped", 32'(wrapped), 32'd0);

        tbl[0] = '{s: 4'h1, lim: 8'd0,  pct: 100, exp_cnt: 15, exp_wrap: 1'b1, chk_sat: 1'b1};
        tbl[1] = '{s: 4'h1, lim: 8'd5,  pct: 100, exp_cnt: 5,  exp_wrap: 1'b0, chk_sat: 1'b0};
        tbl[2] = '{s: 4'h1, lim: 8'd0,  pct: 50,  exp_cnt: 15, exp_wrap: 1'b1, chk_sat: 1'b0};
        tbl[3] = '{s: 4'h0, lim: 8'd0,  pct: 100, exp_cnt: 1,  exp_wrap: 1'b1, chk_sat: 1'b0};
        tbl[4] = '{s: 4'hF, lim: 8'd0,  pct: 70,  exp_cnt: 15, exp_wrap: 1'b1, chk_sat: 1'b0};
        tbl[5] = '{s: 4'h8, lim: 8'd1,  pct: 100, exp_cnt: 1,  exp_wrap: 1'b0, chk_sat: 1'b0};
        tbl[6] = '{s: 4'h3, lim: 8'd15, pct: 100, exp_cnt: 15, exp_wrap: 1'b0, chk_sat: 1'b0};
        tbl[7] = '{s: 4'h3, lim: 8'd16, pct: 60,  exp_cnt: 15, exp_wrap: 1'b1, chk_sat: 1'b0};
        for (int i = 0; i < 8; i++) run_check($sformatf("tbl%0d", i), tbl[i]);

        for (int r = 0; r < 10; r++) begin
            rv.s   = 4'($urandom_range(15));
            rv.lim = 8'($urandom_range(20));
            rv.pct = int'($urandom_range(100, 30));
            build_model(rv.s, rv.lim);
            rv.exp_cnt  = exp_q.size();
            rv.exp_wrap = !(rv.lim != 0 && exp_q.size() == int'(rv.lim));
            rv.chk_sat  = 1'b0;
            run_check($sformatf("rnd%0d", r), rv);
        end

        // Pause asserted in the cycle of the 3rd transfer.
        start_run(4'h1, 8'd0);
        out_ready = 1'b1;
        tick(); tick();
        check("pause pre data", 32'(out_data), 32'h4);
        pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("pause valid", 32'(out_valid), 32'd0);
            check("pause count", 32'(count), 32'd3);
            check("pause busy", 32'(busy), 32'd1);
        end
        pause = 1'b0;
        tick();
        check("resume valid", 32'(out_valid), 32'd1);
        check("resume data", 32'(out_data), 32'h2);
        tick();
        check("resume next", 32'(out_data), 32'h9);
        do_abort();

        // start during RUN is ignored.
        start_run(4'h1, 8'd0);
        seed = 4'hF; start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_run data", 32'(out_data), 32'h1);
        check("start_in_run count", 32'(count), 32'd0);
        do_abort();

        // start and abort together in IDLE: abort wins.
        seed = 4'h5; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort busy", 32'(busy), 32'd0);
        check("start_abort valid", 32'(out_valid), 32'd0);

        for (int m = 0; m < 2; m++) begin
            start_run(4'h1, 8'd0);
            out_ready = 1'b1;
            for (int k = 0; k < 6; k++) tick();
            check("mid count6", 32'(count), 32'd6);
            check("mid data", 32'(out_data), 32'h6);
            if (m == 0) abort = 1'b1; else rst = 1'b1;
            tick();
            abort = 1'b0; rst = 1'b0; out_ready = 1'b0;
            check("stop valid", 32'(out_valid), 32'd0);
            check("stop count", 32'(count), 32'd0);
            check("stop busy", 32'(busy), 32'd0);
            if (m == 1) check("rst data", 32'(out_data), 32'd0);
            start_run(4'hF, 8'd0);
            check("restart valid", 32'(out_valid), 32'd1);
            check("restart data", 32'(out_data), 32'hF);
            do_abort();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
